decode_stage: RTL and testbench
===============================

# decode_stage

Registered, flow-controlled RISC-V instruction decode stage with a 2-entry skid buffer, placed between fetch and register-read/execute in the multi-cycle and pipelined cores. It accepts one 32-bit instruction plus its PC per valid/ready handshake, decodes control signals, sign-extended immediate and absolute branch/jump target (PC + imm), and presents them registered one cycle later. It adds full R/I funct3/funct7 ALU selection, a separate LOAD opcode, a flush, and optional illegal-instruction detection.

## Interface
- XLEN, 32: datapath width (32 or 64); imm, pc and target are XLEN bits; the instruction is always 32 bits.
- CNT_W, 8: width of illegal_count.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low
- in_valid  in  1  instruction offered
- in_ready  out  1  stage can accept; registered
- in_instr  in  32  instruction word
- in_pc  in  XLEN  instruction address
- flush  in  1  discard all held and incoming instructions
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  downstream accepts bundle
- out_alu_op  out  4  ADD=0, ADDI=1, LOAD=2, STORE=3, LUI=4, JUMP=5, OR=6, AND=7, BRANCH=8, SUB=9, NOP=15
- out_we, out_mem_read, out_mem_write, out_branch, out_jump  out  1 each  control flags
- out_alu_src  out  2  00 reg, 01 U-imm, 10 imm
- out_imm, out_target, out_pc  out  XLEN  immediate, PC+imm, passthrough PC
- out_rs1, out_rs2, out_rd  out  5  instr[19:15], [24:20], [11:7]
- out_illegal  out  1  bundle carries an illegal instruction
- illegal_count  out  CNT_W  saturating count of illegal instructions accepted

## Operation
- Decode by opcode: R 0110011, OP-IMM 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, LUI 0110111, JAL 1101111.
- R: funct3 000 & funct7[5]=0 -> ADD; funct3 000 & funct7[5]=1 -> SUB; 110 -> OR; 111 -> AND; we=1, alu_src=00.
- OP-IMM: funct3 000 -> ADDI, 110 -> OR, 111 -> AND; we=1, alu_src=10.
- LOAD: LOAD, we=1, mem_read=1, alu_src=10. STORE: STORE, mem_write=1, alu_src=10.
- BRANCH: BRANCH, branch=1, alu_src=10. LUI: LUI, we=1, alu_src=01. JAL: JUMP, jump=1, we=1.
- Immediates I/S/B/U/J per the RISC-V spec, sign-extended from instr[31] to XLEN; U = {instr[31:12],12'b0} sign-extended. Other opcodes: imm=0.
- out_target = in_pc + imm modulo 2^XLEN for B and J; 0 otherwise.
- Any unlisted opcode/funct combination: alu_op=NOP; all control flags 0.
- Buffer FSM on occupancy: EMPTY(0), ONE(1, output reg), TWO(2, output + skid).
  - EMPTY: accept -> ONE.
  - ONE: accept & !out_ready -> TWO; accept & out_ready -> ONE (replace); out_ready & !accept -> EMPTY.
  - TWO: out_ready -> ONE (skid moves to output); in_ready=0.
- in_ready = (state != TWO), registered; accept = in_valid & in_ready.
- flush (highest priority): next state EMPTY, input on the flush cycle dropped, illegal_count not incremented for it.

## Timing
- Latency 1 cycle: bundle accepted at edge N is visible with out_valid=1 after edge N.
- Throughput 1/cycle while out_ready=1; out_* held stable while out_valid & !out_ready.
- Skid entry leaves in order; no bundle reordered, duplicated or lost except by flush.
- Reset (async assert, any time, including mid-transfer): state EMPTY, out_valid=0, in_ready=1, all out_* = 0 except out_alu_op=NOP, illegal_count=0. Release takes effect on next clk edge.
- Simultaneous accept and drain in TWO is impossible (in_ready=0).

## Configuration
- DECODE_ILLEGAL_EN defined: unlisted opcode/funct3/funct7 sets out_illegal=1 (alu_op=NOP, flags 0); illegal_count increments on each accepted illegal instruction, saturating at 2^CNT_W-1.
- Undefined: out_illegal and illegal_count tied to 0; unlisted encodings still decode as NOP.

## Test plan
- Reset then in_instr=0x00500093 (addi x1,x0,5), pc=0x100, out_ready=1 -> next cycle out_alu_op=1, imm=5, rd=1, we=1, alu_src=10.
- R-type 0x40208133 (sub x2,x1,x2) -> alu_op=9; 0x0020F1B3 (and) -> alu_op=7.
- JAL 0xFF9FF0EF at pc=0x200 -> imm=0xFFFFFFF8, target=0x1F8, jump=1, we=1.
- out_ready=0, present 3 back-to-back instructions -> first two held, in_ready=0 after second; release out_ready -> emerge in order on consecutive cycles.
- State TWO, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, nothing emerges.
- With DECODE_ILLEGAL_EN, CNT_W=2: 5 accepted instructions 0xFFFFFFFF -> out_illegal=1 each, illegal_count saturates at 3; async rst mid-stream -> count 0, out_valid 0 immediately.

Source files
------------

// File: rtl/decode_stage.sv
// Registered RV32/64 decode stage with a 2-entry skid buffer and flush.
// Define DECODE_ILLEGAL_EN to flag illegal encodings and count them (saturating).
module decode_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [XLEN-1:0]   in_pc,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_alu_op,
    output logic              out_we,
    output logic              out_mem_read,
    output logic              out_mem_write,
    output logic              out_branch,
    output logic              out_jump,
    output logic [1:0]        out_alu_src,
    output logic [XLEN-1:0]   out_imm,
    output logic [XLEN-1:0]   out_target,
    output logic [XLEN-1:0]   out_pc,
    output logic [4:0]        out_rs1,
    output logic [4:0]        out_rs2,
    output logic [4:0]        out_rd,
    output logic              out_illegal,
    output logic [CNT_W-1:0]  illegal_count
);

    localparam logic [3:0] OP_ADD    = 4'd0;
    localparam logic [3:0] OP_ADDI   = 4'd1;
    localparam logic [3:0] OP_LOAD   = 4'd2;
    localparam logic [3:0] OP_STORE  = 4'd3;
    localparam logic [3:0] OP_LUI    = 4'd4;
    localparam logic [3:0] OP_JUMP   = 4'd5;
    localparam logic [3:0] OP_OR     = 4'd6;
    localparam logic [3:0] OP_AND    = 4'd7;
    localparam logic [3:0] OP_BRANCH = 4'd8;
    localparam logic [3:0] OP_SUB    = 4'd9;
    localparam logic [3:0] OP_NOP    = 4'd15;

    typedef struct packed {
        logic [3:0]      alu_op;
        logic            we;
        logic            mem_read;
        logic            mem_write;
        logic            branch;
        logic            jump;
        logic [1:0]      alu_src;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] target;
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            illegal;
    } bundle_t;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t          state_q, state_d;
    bundle_t         dec, out_q, skid_q;
    logic            in_ready_q;
    logic            accept;
    logic            load_out, load_skid, move_skid;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign imm_i = XLEN'($signed(in_instr[31:20]));
    assign imm_s = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
    assign imm_b = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({in_instr[31:12], 12'b0}));
    assign imm_j = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0}));

    // Every legal encoding maps to a non-NOP op, so NOP doubles as the illegal marker.
    always_comb begin
        dec        = '0;
        dec.alu_op = OP_NOP;
        dec.pc     = in_pc;
        dec.rs1    = in_instr[19:15];
        dec.rs2    = in_instr[24:20];
        dec.rd     = in_instr[11:7];
        case (in_instr[6:0])
            7'b0110011: begin
                case (in_instr[14:12])
                    3'b000: begin dec.alu_op = in_instr[30] ? OP_SUB : OP_ADD; dec.we = 1'b1; end
                    3'b110: begin dec.alu_op = OP_OR;  dec.we = 1'b1; end
                    3'b111: begin dec.alu_op = OP_AND; dec.we = 1'b1; end
                    default: ;
                endcase
            end
            7'b0010011: begin
                dec.imm = imm_i;
                case (in_instr[14:12])
                    3'b000: begin dec.alu_op = OP_ADDI; dec.we = 1'b1; dec.alu_src = 2'b10; end
                    3'b110: begin dec.alu_op = OP_OR;   dec.we = 1'b1; dec.alu_src = 2'b10; end
                    3'b111: begin dec.alu_op = OP_AND;  dec.we = 1'b1; dec.alu_src = 2'b10; end
                    default: ;
                endcase
            end
            7'b0000011: begin
                dec.imm      = imm_i;
                dec.alu_op   = OP_LOAD;
                dec.we       = 1'b1;
                dec.mem_read = 1'b1;
                dec.alu_src  = 2'b10;
            end
            7'b0100011: begin
                dec.imm       = imm_s;
                dec.alu_op    = OP_STORE;
                dec.mem_write = 1'b1;
                dec.alu_src   = 2'b10;
            end
            7'b1100011: begin
                dec.imm     = imm_b;
                dec.target  = in_pc + imm_b;
                dec.alu_op  = OP_BRANCH;
                dec.branch  = 1'b1;
                dec.alu_src = 2'b10;
            end
            7'b0110111: begin
                dec.imm     = imm_u;
                dec.alu_op  = OP_LUI;
                dec.we      = 1'b1;
                dec.alu_src = 2'b01;
            end
            7'b1101111: begin
                dec.imm    = imm_j;
                dec.target = in_pc + imm_j;
                dec.alu_op = OP_JUMP;
                dec.jump   = 1'b1;
                dec.we     = 1'b1;
            end
            default: ;
        endcase
`ifdef DECODE_ILLEGAL_EN
        dec.illegal = (dec.alu_op == OP_NOP);
`endif
    end

    assign accept = in_valid & in_ready_q;

    always_comb begin
        state_d   = state_q;
        load_out  = 1'b0;
        load_skid = 1'b0;
        move_skid = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: if (accept) begin state_d = ONE; load_out = 1'b1; end
                ONE: begin
                    if (accept && !out_ready) begin
                        state_d   = TWO;
                        load_skid = 1'b1;
                    end else if (accept) begin
                        load_out = 1'b1;
                    end else if (out_ready) begin
                        state_d = EMPTY;
                    end
                end
                TWO: if (out_ready) begin state_d = ONE; move_skid = 1'b1; end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= EMPTY;
            in_ready_q   <= 1'b1;
            out_q        <= '0;
            out_q.alu_op <= OP_NOP;
            skid_q       <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != TWO);
            if (load_out)
                out_q <= dec;
            else if (move_skid)
                out_q <= skid_q;
            if (load_skid)
                skid_q <= dec;
        end
    end

`ifdef DECODE_ILLEGAL_EN
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            count_q <= '0;
        else if (accept && !flush && dec.illegal && (count_q != '1))
            count_q <= count_q + 1'b1;
    end

    assign illegal_count = count_q;
`else
    assign illegal_count = '0;
`endif

    assign in_ready      = in_ready_q;
    assign out_valid     = (state_q != EMPTY);
    assign out_alu_op    = out_q.alu_op;
    assign out_we        = out_q.we;
    assign out_mem_read  = out_q.mem_read;
    assign out_mem_write = out_q.mem_write;
    assign out_branch    = out_q.branch;
    assign out_jump      = out_q.jump;
    assign out_alu_src   = out_q.alu_src;
    assign out_imm       = out_q.imm;
    assign out_target    = out_q.target;
    assign out_pc        = out_q.pc;
    assign out_rs1       = out_q.rs1;
    assign out_rs2       = out_q.rs2;
    assign out_rd        = out_q.rd;
    assign out_illegal   = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed decodes, backpressure, flush,
// async reset and (with DECODE_ILLEGAL_EN) saturating illegal counting.
module tb_decode_stage;

    localparam int XLEN  = 32;
    localparam int CNT_W = 2;
`ifdef DECODE_ILLEGAL_EN
    localparam bit ILL = 1'b1;
`else
    localparam bit ILL = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [XLEN-1:0]  in_pc;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       out_alu_op;
    logic             out_we, out_mem_read, out_mem_write, out_branch, out_jump;
    logic [1:0]       out_alu_src;
    logic [XLEN-1:0]  out_imm, out_target, out_pc;
    logic [4:0]       out_rs1, out_rs2, out_rd;
    logic             out_illegal;
    logic [CNT_W-1:0] illegal_count;

    decode_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_alu_op(out_alu_op), .out_we(out_we), .out_mem_read(out_mem_read),
        .out_mem_write(out_mem_write), .out_branch(out_branch), .out_jump(out_jump),
        .out_alu_src(out_alu_src), .out_imm(out_imm), .out_target(out_target),
        .out_pc(out_pc), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_illegal(out_illegal), .illegal_count(illegal_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // flags = {we, mem_read, mem_write, branch, jump}
    typedef struct packed {
        logic [3:0]  alu;
        logic [4:0]  flags;
        logic [1:0]  src;
        logic [31:0] imm;
        logic [31:0] target;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: compare the presented bundle at the falling edge, then step past the rising edge.
    task automatic cycle();
        exp_t o;
        @(negedge clk);
        if (rst && out_valid) begin
            o = {out_alu_op, out_we, out_mem_read, out_mem_write, out_branch, out_jump,
                 out_alu_src, out_imm, out_target, out_pc, out_rs1, out_rs2, out_rd, out_illegal};
            if (sb.size() == 0) begin
                check("unexpected_bundle", 128'(out_valid), 128'(0));
            end else begin
                check("bundle", 128'(o), 128'(sb[0]));
                if (out_ready) void'(sb.pop_front());
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] instr, input logic [31:0] pc, input logic [3:0] alu,
                        input logic [4:0] flags, input logic [1:0] src, input logic [31:0] imm,
                        input logic [31:0] target, input logic ill);
        exp_t e;
        int   waited;
        e.alu = alu; e.flags = flags; e.src = src; e.imm = imm; e.target = target;
        e.pc = pc; e.rs1 = instr[19:15]; e.rs2 = instr[24:20]; e.rd = instr[11:7]; e.ill = ill;
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        waited   = 0;
        while (!in_ready && waited < 20) begin
            cycle();
            waited++;
        end
        if (!in_ready)
            check("accept_timeout", 128'(in_ready), 128'(1));
        else
            sb.push_back(e);
        cycle();
        in_valid = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_out_valid"}, 128'(out_valid), 128'(0));
        check({tag, "_in_ready"}, 128'(in_ready), 128'(1));
        check({tag, "_alu_op"}, 128'(out_alu_op), 128'(15));
        check({tag, "_flags"}, 128'({out_we, out_mem_read, out_mem_write, out_branch, out_jump}), 128'(0));
        check({tag, "_imm"}, 128'(out_imm), 128'(0));
        check({tag, "_count"}, 128'(illegal_count), 128'(0));
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_pc     = '0;
        flush     = 1'b0;
        out_ready = 1'b1;
        #12;
        check_reset_state("reset");
        check("reset_target", 128'(out_target), 128'(0));
        rst = 1'b1;
        cycle();

        // Directed decodes at full throughput
        send(32'h00500093, 32'h100, 4'd1, 5'b10000, 2'b10, 32'd5, 32'd0, 1'b0);
        send(32'h40208133, 32'h104, 4'd9, 5'b10000, 2'b00, 32'd0, 32'd0, 1'b0);
        send(32'h0020F1B3, 32'h108, 4'd7, 5'b10000, 2'b00, 32'd0, 32'd0, 1'b0);
        send(32'hFF9FF0EF, 32'h200, 4'd5, 5'b10001, 2'b00, 32'hFFFFFFF8, 32'h1F8, 1'b0);
        send(32'hFFC12283, 32'h204, 4'd2, 5'b11000, 2'b10, 32'hFFFFFFFC, 32'd0, 1'b0);
        send(32'h00612423, 32'h208, 4'd3, 5'b00100, 2'b10, 32'd8, 32'd0, 1'b0);
        send(32'hFE2088E3, 32'h300, 4'd8, 5'b00010, 2'b10, 32'hFFFFFFF0, 32'h2F0, 1'b0);
        send(32'h02000063, 32'hFFFFFFF0, 4'd8, 5'b00010, 2'b10, 32'h20, 32'h10, 1'b0);
        send(32'h800003B7, 32'h30C, 4'd4, 5'b10000, 2'b01, 32'h80000000, 32'd0, 1'b0);
        send(32'hFFF0E193, 32'h310, 4'd6, 5'b10000, 2'b10, 32'hFFFFFFFF, 32'd0, 1'b0);
        send(32'h0020E233, 32'h314, 4'd6, 5'b10000, 2'b00, 32'd0, 32'd0, 1'b0);
        send(32'h002082B3, 32'h318, 4'd0, 5'b10000, 2'b00, 32'd0, 32'd0, 1'b0);
        send(32'hFFFFFFFF, 32'h31C, 4'd15, 5'b00000, 2'b00, 32'd0, 32'd0, ILL);
        send(32'h00209133, 32'h320, 4'd15, 5'b00000, 2'b00, 32'd0, 32'd0, ILL);
        repeat (3) cycle();
        check("drain_main", 128'(sb.size()), 128'(0));

        // Backpressure: fill both entries, third waits, then all emerge in order
        out_ready = 1'b0;
        send(32'hFFC12283, 32'h400, 4'd2, 5'b11000, 2'b10, 32'hFFFFFFFC, 32'd0, 1'b0);
        send(32'h00612423, 32'h404, 4'd3, 5'b00100, 2'b10, 32'd8, 32'd0, 1'b0);
        in_valid = 1'b1;
        in_instr = 32'h800003B7;
        in_pc    = 32'h408;
        cycle();
        check("in_ready_full_a", 128'(in_ready), 128'(0));
        cycle();
        check("in_ready_full_b", 128'(in_ready), 128'(0));
        out_ready = 1'b1;
        send(32'h800003B7, 32'h408, 4'd4, 5'b10000, 2'b01, 32'h80000000, 32'd0, 1'b0);
        repeat (3) cycle();
        check("drain_backpressure", 128'(sb.size()), 128'(0));

        // Flush while full with an instruction offered
        out_ready = 1'b0;
        send(32'h00500093, 32'h500, 4'd1, 5'b10000, 2'b10, 32'd5, 32'd0, 1'b0);
        send(32'h40208133, 32'h504, 4'd9, 5'b10000, 2'b00, 32'd0, 32'd0, 1'b0);
        in_valid = 1'b1;
        in_instr = 32'h002082B3;
        in_pc    = 32'h508;
        flush    = 1'b1;
        cycle();
        flush    = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        check("flush_out_valid", 128'(out_valid), 128'(0));
        check("flush_in_ready", 128'(in_ready), 128'(1));
        out_ready = 1'b1;
        repeat (3) cycle();
        check("flush_nothing_emerges", 128'(out_valid), 128'(0));

        // Async reset while a transfer is in flight
        out_ready = 1'b0;
        send(32'h00500093, 32'h600, 4'd1, 5'b10000, 2'b10, 32'd5, 32'd0, 1'b0);
        in_valid = 1'b1;
        in_instr = 32'hFFFFFFFF;
        #2;
        rst = 1'b0;
        #1;
        check_reset_state("midreset");
        sb.delete();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Flush drops an illegal instruction without counting it
        in_valid = 1'b1;
        in_instr = 32'hFFFFFFFF;
        in_pc    = 32'h700;
        flush    = 1'b1;
        cycle();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_drop_valid", 128'(out_valid), 128'(0));
        check("flush_drop_count", 128'(illegal_count), 128'(0));

        // Illegal stream: count saturates at 2^CNT_W-1
        for (int k = 1; k <= 5; k++) begin
            send(32'hFFFFFFFF, 32'h800 + 32'(4 * k), 4'd15, 5'b00000, 2'b00, 32'd0, 32'd0, ILL);
            check("illegal_count", 128'(illegal_count), 128'(ILL ? ((k > 3) ? 3 : k) : 0));
        end
        repeat (2) cycle();
        check("drain_illegal", 128'(sb.size()), 128'(0));

        // Async reset mid-stream clears the count at once
        in_valid = 1'b1;
        in_instr = 32'hFFFFFFFF;
        cycle();
        #2;
        rst = 1'b0;
        #1;
        check("stream_reset_count", 128'(illegal_count), 128'(0));
        check("stream_reset_valid", 128'(out_valid), 128'(0));
        sb.delete();
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
